// File: rtl/fir_param_mac_if.sv
// rtl/fir_param_mac_if.sv - sample, coefficient and result signals of the time-multiplexed FIR
interface fir_param_mac_if #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int OW = 24
);
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic          coef_we;
    logic [5:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic [OW-1:0] data_o;
    logic          valid_o;

    modport master (
        output data_i, valid_i, coef_we, coef_addr, coef_data,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, coef_we, coef_addr, coef_data,
        output ready_o, data_o, valid_o
    );
endinterface

// File: rtl/fir_param_mac.sv
// rtl/fir_param_mac.sv - NTAPS-tap FIR filter sharing one multiplier-accumulator across all taps
module fir_param_mac #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int NTAPS = 17,
    parameter int OW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    fir_param_mac_if.slave bus
);
    localparam int PW = DW + CW;
    localparam int FW = DW + CW + $clog2(NTAPS);
    localparam int KW = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state, state_nx;
    logic signed [DW-1:0] dline [NTAPS];
    logic signed [CW-1:0] coef  [NTAPS];
    logic signed [FW-1:0] acc;
    logic [KW-1:0]        tap;
    logic signed [OW-1:0] dout;
    logic                 accept;
    logic                 last_tap;
    logic signed [PW-1:0] prod;
    logic signed [FW-1:0] sum;
    logic signed [OW-1:0] sum_sat;

    assign bus.ready_o = (state == IDLE) && rst;
    assign accept      = bus.valid_i && bus.ready_o;
    assign last_tap    = (tap == KW'(NTAPS - 1));
    assign prod        = PW'(coef[tap]) * PW'(dline[tap]);
    assign sum         = acc + FW'(prod);
    assign bus.valid_o = (state == OUT);
    assign bus.data_o  = dout;

    // Narrow outputs clamp when the discarded upper bits are not a pure sign extension.
    generate
        if (OW >= FW) begin : g_wide
            assign sum_sat = OW'(sum);
        end else begin : g_sat
            logic [FW-OW:0] top;
            assign top     = sum[FW-1:OW-1];
            assign sum_sat = (&top || !(|top)) ? sum[OW-1:0] :
                             (sum[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (last_tap) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= (i == 0) ? CW'(1) : '0;
            end
            acc  <= '0;
            tap  <= '0;
            dout <= '0;
        end else begin
            // Matching only i < NTAPS drops writes to out-of-range addresses.
            if (state == IDLE && bus.coef_we) begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (bus.coef_addr == 6'(i)) coef[i] <= bus.coef_data;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        dline[0] <= bus.data_i;
                        for (int i = 1; i < NTAPS; i++) dline[i] <= dline[i-1];
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (last_tap) begin
                        dout <= sum_sat;
                        tap  <= '0;
                    end else begin
                        tap <= tap + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_param_mac.sv
// tb/tb_fir_param_mac.sv - directed-vector bench for fir_param_mac (24-bit and saturating 16-bit outputs)
module tb_fir_param_mac;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       cwe;
    logic [5:0] caddr;
    logic [7:0] cdata;

    int errors = 0;
    int checks = 0;
    int ya, yb, lat;

    always #5 clk = ~clk;

    fir_param_mac_if #(.DW(8), .CW(8), .OW(24)) ifa ();
    fir_param_mac_if #(.DW(8), .CW(8), .OW(16)) ifb ();

    assign ifa.data_i    = din;
    assign ifa.valid_i   = vin;
    assign ifa.coef_we   = cwe;
    assign ifa.coef_addr = caddr;
    assign ifa.coef_data = cdata;
    assign ifb.data_i    = din;
    assign ifb.valid_i   = vin;
    assign ifb.coef_we   = cwe;
    assign ifb.coef_addr = caddr;
    assign ifb.coef_data = cdata;

    fir_param_mac #(.DW(8), .CW(8), .NTAPS(17), .OW(24)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    fir_param_mac #(.DW(8), .CW(8), .NTAPS(17), .OW(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ifa.ready_o && n < 60) begin
            tick();
            n++;
        end
        if (!ifa.ready_o) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int x, input bit we, input int wa, input int wd,
                        output int oa, output int ob, output int ol);
        wait_ready();
        din   = 8'(x);
        vin   = 1'b1;
        cwe   = we;
        caddr = 6'(wa);
        cdata = 8'(wd);
        tick();
        vin = 1'b0;
        cwe = 1'b0;
        ol  = 0;
        while (!ifa.valid_o && ol < 40) begin
            tick();
            ol++;
        end
        if (!ifa.valid_o) check("valid_timeout", 0, 1);
        oa = $signed(ifa.data_o);
        ob = $signed(ifb.data_o);
    endtask

    task automatic write_coef(input int a, input int d);
        wait_ready();
        cwe   = 1'b1;
        caddr = 6'(a);
        cdata = 8'(d);
        tick();
        cwe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        vin = 1'b0;
        cwe = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int acc_cnt, bad_gap, last, zsum, pulses;
        rst = 1'b0; din = '0; vin = 1'b0; cwe = 1'b0; caddr = '0; cdata = '0;
        tick();
        tick();
        check("rst_ready", int'(ifa.ready_o), 0);
        check("rst_valid", int'(ifa.valid_o), 0);
        check("rst_data", $signed(ifa.data_o), 0);
        rst = 1'b1;
        tick();
        check("ready_after_rst", int'(ifa.ready_o), 1);

        // identity filter after reset
        send(5, 0, 0, 0, ya, yb, lat);
        check("ident_5", ya, 5);
        check("ident_5_lat", lat, 17);
        send(-3, 0, 0, 0, ya, yb, lat);
        check("ident_m3", ya, -3);
        check("ident_m3_lat", lat, 17);
        tick();
        check("valid_one_cycle", int'(ifa.valid_o), 0);
        repeat (3) tick();
        check("hold_data", $signed(ifa.data_o), -3);

        // impulse response with h[k] = k+1
        do_reset();
        for (int k = 0; k < 17; k++) write_coef(k, k + 1);
        for (int j = 0; j < 17; j++) begin
            send((j == 0) ? 1 : 0, 0, 0, 0, ya, yb, lat);
            check($sformatf("impulse_%0d", j), ya, j + 1);
        end

        // extreme values, full precision and saturated
        do_reset();
        for (int k = 0; k < 17; k++) write_coef(k, -128);
        for (int j = 0; j < 17; j++) begin
            send(-128, 0, 0, 0, ya, yb, lat);
            if (j == 0) begin
                check("extreme_first_a", ya, 16384);
                check("extreme_first_b", yb, 16384);
            end
            if (j == 16) begin
                check("extreme_full_a", ya, 278528);
                check("extreme_sat_b", yb, 32767);
            end
        end

        // flow control: valid held high for 100 cycles
        do_reset();
        din = 8'd1;
        vin = 1'b1;
        acc_cnt = 0; bad_gap = 0; last = -1;
        for (int c = 0; c < 100; c++) begin
            if (ifa.ready_o) begin
                if (last >= 0 && c - last != 19) bad_gap++;
                last = c;
                acc_cnt++;
            end
            tick();
        end
        vin = 1'b0;
        check("flow_accepts", acc_cnt, 6);
        check("flow_gaps", bad_gap, 0);
        wait_ready();

        // coefficient writes during MAC and out of range are dropped
        do_reset();
        din = 8'd2;
        vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (5) tick();
        cwe = 1'b1; caddr = 6'd1; cdata = 8'd9;
        tick();
        cwe = 1'b0;
        wait_ready();
        write_coef(20, 5);
        send(3, 0, 0, 0, ya, yb, lat);
        check("coef_we_in_mac", ya, 3);
        zsum = 0;
        for (int j = 0; j < 16; j++) begin
            send(0, 0, 0, 0, ya, yb, lat);
            zsum += (ya < 0) ? -ya : ya;
        end
        check("coef_addr_20", zsum, 0);

        // coefficient write on the accept edge
        do_reset();
        send(4, 1, 0, 3, ya, yb, lat);
        check("same_edge", ya, 12);

        // reset during MAC aborts the computation
        do_reset();
        send(5, 0, 0, 0, ya, yb, lat);
        check("abort_pre", ya, 5);
        wait_ready();
        din = 8'd9;
        vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        #1;
        check("abort_valid", int'(ifa.valid_o), 0);
        check("abort_data", $signed(ifa.data_o), 0);
        check("abort_ready", int'(ifa.ready_o), 0);
        tick();
        rst = 1'b1;
        #1;
        check("abort_ready_after", int'(ifa.ready_o), 1);
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (ifa.valid_o) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        send(7, 0, 0, 0, ya, yb, lat);
        check("abort_next", ya, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_param_mac.md
FIR_PARAM_MAC -- requirements
Module: fir_param_mac

Interface
REQ-001 Parameter DW, default 8: input sample width, signed two's complement.
REQ-002 Parameter CW, default 8: coefficient width, signed two's complement.
REQ-003 Parameter NTAPS, default 17: number of taps, legal range 2..64.
REQ-004 Parameter OW, default 24: output width; full-precision width FW = DW+CW+clog2(NTAPS).
REQ-005 Port clk, input, 1: single clock, rising-edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port data_i, input, DW: input sample.
REQ-008 Port valid_i, input, 1: data_i valid.
REQ-009 Port ready_o, output, 1: block accepts a sample this cycle.
REQ-010 Port coef_we, input, 1: coefficient write strobe.
REQ-011 Port coef_addr, input, 6: tap index.
REQ-012 Port coef_data, input, CW: coefficient value.
REQ-013 Port data_o, output, OW: filter result, signed.
REQ-014 Port valid_o, output, 1: data_o valid, one-cycle pulse.

Function
REQ-015 Output y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], computed with one time-multiplexed multiplier-accumulator.
REQ-016 FSM states: IDLE, MAC, OUT; ready_o = 1 only in IDLE with rst high.
REQ-017 Accept = valid_i & ready_o at a rising edge E0; at E0 x shifts into the NTAPS-deep delay line (x[n] at position 0, oldest sample discarded), accumulator clears, FSM goes IDLE->MAC.
REQ-018 In MAC, edges E1..E_NTAPS each add h[k]*x[n-k], k = 0..NTAPS-1 in ascending order; a tap counter tracks k.
REQ-019 At E_NTAPS, data_o loads the final sum and FSM goes MAC->OUT; valid_o is high for exactly the cycle in OUT.
REQ-020 At E_NTAPS+1, FSM goes OUT->IDLE; throughput is one sample per NTAPS+2 cycles; valid_i while ready_o low is ignored, with no sample lost or queued.
REQ-021 data_o holds its last value until the next OUT load.
REQ-022 Products are CW+DW bits; the accumulator is FW bits and cannot overflow.
REQ-023 If OW >= FW, data_o is the sign-extended sum; if OW < FW, data_o saturates to [-2^(OW-1), 2^(OW-1)-1].
REQ-024 Coefficient write honoured only in IDLE with coef_addr < NTAPS: h[coef_addr] <= coef_data at the edge; otherwise the write is silently dropped.
REQ-025 coef_we and an accepted sample on the same edge: both take effect, and that sample's MAC uses the new coefficient.
REQ-026 No combinational path from any input to data_o or valid_o.

Reset
REQ-027 While rst low: FSM = IDLE, ready_o = 0, valid_o = 0, data_o = 0, delay line = 0, accumulator = 0, tap counter = 0, h[0] = 1, h[1..NTAPS-1] = 0 (identity filter).
REQ-028 Reset assertion mid-MAC or mid-OUT aborts the computation immediately with no valid_o pulse; ready_o = 1 from the first cycle after rst deasserts.

Verification
REQ-029 Reset defaults: after reset, feed 5 then -3 -> data_o = 5 then -3; each valid_o pulse is exactly NTAPS = 17 cycles after its accept edge.
REQ-030 Impulse: load h[k] = k+1 (k = 0..16), feed 1 followed by 16 zeros -> outputs 1, 2, ..., 17 in order.
REQ-031 Extreme value: all h = -128, 17 inputs of -128 -> 17th output = 278528; rerun with OW = 16 -> 32767 (saturated).
REQ-032 Flow control: valid_i held high for 100 cycles -> exactly one accept every 19 cycles and ready_o low between accepts; coef_we pulsed during MAC -> coefficients unchanged; coef_addr = 20 in IDLE -> no change.
REQ-033 Same-edge case: h[0] = 1, then write h[0] = 3 with coef_we on the same edge as accepting data 4 -> data_o = 12.
REQ-034 Abort: rst pulsed low at cycle 8 of MAC -> valid_o, data_o = 0 at once, no late pulse; next sample 7 gives data_o = 7 (identity coefficients, cleared delay line).
